// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// port index constants and the wait-counter width.
package mem_arb_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] DONE   = 2'b10;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_EXT = 1'b1;

    // WAIT is limited to 1..15, so WAIT-1 always fits in four bits
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = IDLE,
        S_ACCESS = ACCESS,
        S_DONE   = DONE
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus.
// master: requesters and memory (environment); slave: the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          gnt;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_rd, mem_wr,
               busy, gnt
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_rd, mem_wr,
               busy, gnt
    );
endinterface

// File: rtl/arb_pick.sv
// Winner selection between the CPU port (0) and the external port (1).
// MEM_ARB_RR_EN defined: ties go to the port that was not granted last.
// MEM_ARB_RR_EN undefined: the CPU port always wins a tie.
module arb_pick
    import mem_arb_pkg::*;
(
    output logic win,
    input  logic req0,
    input  logic req1
`ifdef MEM_ARB_RR_EN
    ,
    input  logic last
`endif
);

    // Sole requester always wins; a tie is resolved by the configured policy
    always_comb begin
        win = PORT_CPU;
        if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            win = ~last;
`else
            win = PORT_CPU;
`endif
        end else if (req1) begin
            win = PORT_EXT;
        end else begin
            win = PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multicycle arbiter for the shared instruction/data memory. Latches one
// request, holds the memory strobes for WAIT cycles, returns registered read
// data per port and pulses that port's ack for one cycle.
// Optional feature: MEM_ARB_RR_EN selects round-robin tie breaking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          AW   = 16,
    parameter int          DW   = 16,
    parameter int unsigned WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             gnt_q, gnt_d;
    logic [DW-1:0]    rdata0_q, rdata0_d;
    logic [DW-1:0]    rdata1_q, rdata1_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             win_s;
`ifdef MEM_ARB_RR_EN
    logic             last_q, last_d;
`endif

    arb_pick u_pick (
        .win  (win_s),
        .req0 (bus.req0),
        .req1 (bus.req1)
`ifdef MEM_ARB_RR_EN
        ,
        .last (last_q)
`endif
    );

    // Next-state, request latching, strobe and ack generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_d    = gnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    if (win_s == PORT_EXT) begin
                        we_d    = bus.we1;
                        addr_d  = bus.addr1;
                        wdata_d = bus.wdata1;
                    end else begin
                        we_d    = bus.we0;
                        addr_d  = bus.addr0;
                        wdata_d = bus.wdata0;
                    end
                    gnt_d    = win_s;
                    cnt_d    = CNT_INIT;
                    mem_rd_d = ~we_d;
                    mem_wr_d = we_d;
`ifdef MEM_ARB_RR_EN
                    last_d   = win_s;
`endif
                    state_d  = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    // strobes stay up through the last wait cycle
                    cnt_d    = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    mem_rd_d = ~we_q;
                    mem_wr_d = we_q;
                end else begin
                    if (!we_q) begin
                        if (gnt_q == PORT_EXT) begin
                            rdata1_d = bus.mem_rdata;
                        end else begin
                            rdata0_d = bus.mem_rdata;
                        end
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                    ack0_d  = (gnt_q == PORT_CPU);
                    ack1_d  = (gnt_q == PORT_EXT);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears strobes and acks immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            we_q     <= 1'b0;
            addr_q   <= {AW{1'b0}};
            wdata_q  <= {DW{1'b0}};
            gnt_q    <= 1'b0;
            rdata0_q <= {DW{1'b0}};
            rdata1_q <= {DW{1'b0}};
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
`ifdef MEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.gnt       = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic checked against a transaction-level model (reference memory,
// expected per-port read data, arbitration rule, cycle timing).
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int WAIT = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   mem_init = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_w1 ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(1)) u_dut_w1 (
        .clk (clk),
        .rst (rst),
        .bus (bus_w1)
    );

    logic [DW-1:0] mem_arr [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] exp_rdata [0:1];
    bit            model_last;
    int            n_checks = 0;
    int            n_errors = 0;
    int            ack_times[$];
    bit            tie_exp [4];

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 16) ? 16'hBEEF : 16'(i * 40503 + 7);
    endfunction

    // Memory behind the main DUT: combinational read, written while mem_wr
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
        end else if (bus.mem_wr) begin
            mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata    = mem_arr[bus.mem_addr[7:0]];
    assign bus_w1.mem_rdata = bus_w1.mem_addr ^ 16'h5A5A;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Arbitration rule: a sole requester wins; ties per configured policy
    function automatic bit model_pick(input bit r0, input bit r1);
        if (r0 && r1) return RR_MODE ? ~model_last : 1'b0;
        return r1;
    endfunction

    // Serve one access of port p; call at a negedge in IDLE with req_p high.
    // Returns at the negedge of the following IDLE cycle.
    task automatic serve(input bit p, input bit drop, input bit pert_en, input logic [15:0] pert_addr);
        logic          we;
        logic [15:0]   a;
        logic [15:0]   d;
        we = p ? bus.we1   : bus.we0;
        a  = p ? bus.addr1 : bus.addr0;
        d  = p ? bus.wdata1 : bus.wdata0;
        model_last = p;
        @(posedge clk);
        for (int i = 0; i < WAIT; i++) begin
            @(negedge clk);
            check_eq("acc_busy",  32'(bus.busy),   32'd1);
            check_eq("acc_gnt",   32'(bus.gnt),    32'(p));
            check_eq("acc_rd",    32'(bus.mem_rd), 32'(!we));
            check_eq("acc_wr",    32'(bus.mem_wr), 32'(we));
            check_eq("acc_addr",  32'(bus.mem_addr), 32'(a));
            if (we) check_eq("acc_wdata", 32'(bus.mem_wdata), 32'(d));
            check_eq("acc_ack",   32'({bus.ack1, bus.ack0}), 32'd0);
            if (i == 0 && pert_en) begin
                if (p) begin
                    bus.addr1 = pert_addr; bus.wdata1 = ~bus.wdata1; bus.we1 = ~bus.we1;
                    if (pert_addr[1]) bus.req1 = 1'b0;
                end else begin
                    bus.addr0 = pert_addr; bus.wdata0 = ~bus.wdata0; bus.we0 = ~bus.we0;
                    if (pert_addr[1]) bus.req0 = 1'b0;
                end
            end
        end
        if (we) ref_mem[a[7:0]] = d;
        else    exp_rdata[p] = ref_mem[a[7:0]];
        @(negedge clk);
        check_eq("done_ack",    32'({bus.ack1, bus.ack0}), p ? 32'd2 : 32'd1);
        check_eq("done_strobe", 32'({bus.mem_wr, bus.mem_rd}), 32'd0);
        check_eq("done_busy",   32'(bus.busy), 32'd1);
        check_eq("done_rdata0", 32'(bus.rdata0), 32'(exp_rdata[0]));
        check_eq("done_rdata1", 32'(bus.rdata1), 32'(exp_rdata[1]));
        if (drop) begin
            if (p) bus.req1 = 1'b0;
            else   bus.req0 = 1'b0;
        end
        @(negedge clk);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
        check_eq("idle_ack",  32'({bus.ack1, bus.ack0}), 32'd0);
    endtask

    initial begin
        bit r0, r1, p;
        {bus.req0, bus.req1, bus.we0, bus.we1} = 4'b0000;
        bus.addr0 = 16'h0000; bus.addr1 = 16'h0000;
        bus.wdata0 = 16'h0000; bus.wdata1 = 16'h0000;
        {bus_w1.req0, bus_w1.req1, bus_w1.we0, bus_w1.we1} = 4'b0000;
        bus_w1.addr0 = 16'h0000; bus_w1.addr1 = 16'h0000;
        bus_w1.wdata0 = 16'h0000; bus_w1.wdata1 = 16'h0000;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        exp_rdata[0] = 16'h0000; exp_rdata[1] = 16'h0000;
        model_last = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_ack",    32'({bus.ack1, bus.ack0}), 32'd0);
        check_eq("rst_rdata0", 32'(bus.rdata0), 32'd0);
        check_eq("rst_rdata1", 32'(bus.rdata1), 32'd0);
        check_eq("rst_strobe", 32'({bus.mem_wr, bus.mem_rd}), 32'd0);
        check_eq("rst_maddr",  32'(bus.mem_addr), 32'd0);
        check_eq("rst_mwdata", 32'(bus.mem_wdata), 32'd0);
        check_eq("rst_busy",   32'(bus.busy), 32'd0);
        check_eq("rst_gnt",    32'(bus.gnt), 32'd0);
        rst = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);

        // Single read by port 0
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
        serve(1'b0, 1'b1, 1'b0, 16'h0000);
        check_eq("read_beef",  32'(bus.rdata0), 32'h0000BEEF);
        check_eq("read_r1_0",  32'(bus.rdata1), 32'd0);

        // Single write by port 1
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0040; bus.wdata1 = 16'h1234;
        serve(1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("write_r1_0", 32'(bus.rdata1), 32'd0);

        // Four back-to-back ties with both requests held
        if (RR_MODE) tie_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
        else         tie_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0021;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0022;
        for (int t = 0; t < 4; t++) serve(tie_exp[t], 1'b0, 1'b0, 16'h0000);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);

        // Input change after grant is ignored
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
        serve(1'b0, 1'b1, 1'b1, 16'h0020);
        check_eq("chg_rdata0", 32'(bus.rdata0), 32'h0000BEEF);

        // Reset during the second ACCESS cycle
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0055;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_rd", 32'(bus.mem_rd), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_eq("mid_rst_strobe", 32'({bus.mem_wr, bus.mem_rd}), 32'd0);
        check_eq("mid_rst_busy",   32'(bus.busy), 32'd0);
        check_eq("mid_rst_rdata",  32'({bus.rdata1, bus.rdata0}), 32'd0);
        check_eq("mid_rst_gnt",    32'(bus.gnt), 32'd0);
        check_eq("mid_rst_ack",    32'({bus.ack1, bus.ack0}), 32'd0);
        bus.req0 = 1'b0;
        exp_rdata[0] = 16'h0000; exp_rdata[1] = 16'h0000;
        model_last = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("post_rst_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
        end
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0010;
        serve(1'b1, 1'b1, 1'b0, 16'h0000);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            r0 = (mode != 1);
            r1 = (mode != 0);
            bus.we0 = 1'($urandom); bus.addr0 = 16'($urandom); bus.wdata0 = 16'($urandom);
            bus.we1 = 1'($urandom); bus.addr1 = 16'($urandom); bus.wdata1 = 16'($urandom);
            bus.req0 = r0; bus.req1 = r1;
            p = model_pick(r0, r1);
            serve(p, 1'b1, ($urandom_range(0, 3) == 0), 16'($urandom));
            if (r0 && r1) serve(~p, 1'b1, 1'b0, 16'h0000);
        end

        // WAIT=1 instance: req0 held through two accesses
        bus_w1.addr0 = 16'h0033; bus_w1.we0 = 1'b0; bus_w1.req0 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus_w1.ack0) begin
                ack_times.push_back(c);
                if (ack_times.size() == 2) bus_w1.req0 = 1'b0;
            end
        end
        check_eq("w1_ack_count", 32'(ack_times.size()), 32'd2);
        if (ack_times.size() == 2) check_eq("w1_ack_gap", 32'(ack_times[1] - ack_times[0]), 32'd3);
        check_eq("w1_rdata0", 32'(bus_w1.rdata0), 32'h00005A69);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Multicycle memory-port arbiter sharing the single unified instruction/data memory between the CPU controller (port 0: fetch, load, store) and a second requester (port 1: program loader / DMA). It latches one request at a time, holds the memory strobes for a fixed number of wait cycles, returns read data and issues a one-cycle acknowledge. It sits between the controller/datapath `IorD` address mux and the memory block.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `WAIT`, 2, cycles memory strobes are held per access; legal range 1..15

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req0` / `req1`  in  1  access request, port 0 / port 1
- `we0` / `we1`  in  1  1 = write, 0 = read
- `addr0` / `addr1`  in  AW  access address
- `wdata0` / `wdata1`  in  DW  write data
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DW  registered read data, per port
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rd` / `mem_wr`  out  1  memory read / write strobes
- `mem_rdata`  in  DW  memory read data
- `busy`  out  1  high in ACCESS or DONE
- `gnt`  out  1  index of the port currently being served

## Operation
- States: IDLE, ACCESS, DONE. Reset goes to IDLE.
- IDLE: if neither `req` is high, stay in IDLE. Otherwise pick a winner (see Configuration), latch its `we`, `addr` and `wdata` into internal registers, set `gnt` to the winner, load `cnt = WAIT-1`, and go to ACCESS.
- ACCESS: `mem_addr`/`mem_wdata` come from the latched registers. `mem_rd = ~we_r` and `mem_wr = we_r`, held for all WAIT cycles. While `cnt != 0`, decrement `cnt`. When `cnt == 0`, on a read capture `mem_rdata` into the winner's `rdata`, then go to DONE.
- DONE: assert the winner's `ack` for one cycle, then go to IDLE.
- Requests are level-sensitive. The requester holds `req` and its inputs stable until `ack`, and drops `req` in the cycle after `ack`. If `req` is still high in IDLE, it is a new access.
- `req` dropped mid-access: the access still completes and `ack` is still issued.
- Input changes after the grant are ignored because the inputs were latched.
- The loser's `req` stays pending. It is served no earlier than the IDLE cycle following DONE.
- On a write, `rdata` of that port is unchanged. `rdata` of the other port is never disturbed.
- Reset value of every output is 0: `ack*`, `rdata*`, `mem_*`, `busy`, `gnt`.
- Reset mid-access: strobes drop asynchronously and no `ack` is issued.

## Timing
- Request sampled high at IDLE edge k → ACCESS for cycles k+1..k+WAIT → `ack` high during cycle k+WAIT+1 → IDLE at k+WAIT+2.
- Per-access occupancy: WAIT+2 cycles. Maximum throughput is one access per WAIT+2 cycles.
- `rdata` is valid in the same cycle as `ack` and holds until that port's next read completes.
- No combinational path from any `req` to any memory strobe. All outputs are registered or decoded from state.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - A 1-bit `last` pointer is updated at each grant. Reset value is 1, so port 0 wins the first tie.
  - On simultaneous requests, the port not equal to `last` wins.
- `MEM_ARB_RR_EN` undefined: fixed priority.
  - Port 0 (CPU) always wins a tie.
  - No `last` register exists.
- In both modes a sole requester is always granted.

## Structure
- Shared package `mem_arb_pkg`:
  - State encoding localparams: IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10.
  - Port index constants: PORT_CPU = 0, PORT_EXT = 1.
- One sub-module, `arb_pick`:
  - Combinational winner selection from `req0`, `req1` and `last`.
  - Contains the `MEM_ARB_RR_EN` conditional.
- The FSM, `cnt`, latch registers and `rdata` registers live in the top module.

## Test plan
- Single read, WAIT=2. Port 0 reads 0x0010 with memory returning 0xBEEF. Expect `mem_rd` high for 2 cycles, then `ack0` for 1 cycle with `rdata0` = 0xBEEF, 4 cycles from sample to IDLE. `rdata1` stays 0.
- Single write. Port 1 writes 0x1234 to 0x0040. Expect `mem_wr` high for 2 cycles with `mem_addr` = 0x0040 and `mem_wdata` = 0x1234, then `ack1`. `rdata1` unchanged.
- Simultaneous requests, repeated 4 times. With `MEM_ARB_RR_EN`: grants alternate 0,1,0,1. Without it: port 0 is granted on every tie.
- Port 0 changes `addr0` from 0x0010 to 0x0020 mid-ACCESS. Expect `mem_addr` to stay 0x0010 and `ack0` to be issued normally.
- `rst` pulled low during the second ACCESS cycle. Expect all outputs 0 immediately, no `ack`, and a later request served normally from IDLE.
- WAIT=1 back-to-back: port 0 holds `req0` high through two accesses. Expect two `ack0` pulses 3 cycles apart.
